// File: rtl/uart_tx_sched_if.sv
// Request/transmitter bundle for uart_tx_sched: requester side, transmitter handshake and status.
// master = scheduler, slave = the environment around it.
interface uart_tx_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data_in;
  logic              baud_tick;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic              start_err;
  logic              active;

  modport master (
    input  req, data_in, baud_tick, tx_busy,
    output tx_start, tx_data, grant, ack, start_err, active
  );

  modport slave (
    output req, data_in, baud_tick, tx_busy,
    input  tx_start, tx_data, grant, ack, start_err, active
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between NREQ producers,
// with start-timeout detection and an enforced idle gap (in baud ticks) after each frame.
module uart_tx_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned START_TMO = 16
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.master bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned TW = $clog2(START_TMO + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAITB, SEND, GAP} state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   winner_q;
  logic [7:0]      tx_data_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ack_q;
  logic            tx_start_q;
  logic            start_err_q;
  logic [TW-1:0]   tmo_q;
  logic [GW-1:0]   gap_q;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [7:0]      pick_data;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   rr_d;

  // Modulo-NREQ increment without relying on NREQ being a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    logic [IW:0] s;
    s = {1'b0, base} + (IW+1)'(off);
    if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
    return s[IW-1:0];
  endfunction

  always_comb begin
    logic [IW-1:0] idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = wrap_add(rr_q, k);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == IW'(k)) begin
        pick_data      = bus.data_in[8*k +: 8];
        pick_onehot[k] = 1'b1;
      end
    end
  end

  assign rr_d = wrap_add(winner_q, 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      winner_q    <= '0;
      tx_data_q   <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      tx_start_q  <= 1'b0;
      start_err_q <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            winner_q   <= pick_idx;
            tx_data_q  <= pick_data;
            grant_q    <= pick_onehot;
            tx_start_q <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          rr_q    <= rr_d;
          tmo_q   <= '0;
          state_q <= WAITB;
        end
        WAITB: begin
          if (bus.tx_busy) begin
            state_q <= SEND;
          end else if (tmo_q == TW'(START_TMO - 1)) begin
            start_err_q <= 1'b1;
            grant_q     <= '0;
            gap_q       <= '0;
            state_q     <= GAP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        SEND: begin
          // grant is still one-hot on the winner here, so it doubles as the ack vector.
          if (!bus.tx_busy) begin
            ack_q   <= grant_q;
            grant_q <= '0;
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (GAP_TICKS == 0) begin
            state_q <= IDLE;
          end else if (bus.baud_tick) begin
            if (gap_q == GW'(GAP_TICKS - 1)) begin
              gap_q   <= '0;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.start_err = start_err_q;
  assign bus.active    = (state_q != IDLE);

endmodule
